// File: rtl/ram_access_ctrl_if.sv
// rtl/ram_access_ctrl_if.sv - request, RAM and status bundle for ram_access_ctrl
// Groups both requester channels, the RAM-side signals and the error/status flags.
// master: requesters + RAM model side (drives i_*); slave: the controller (drives o_*).
interface ram_access_ctrl_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
);
    logic               i_req0_valid;
    logic               i_req0_we;
    logic [1:0]         i_req0_size;
    logic [NB_ADDR-1:0] i_req0_addr;
    logic [NB_DATA-1:0] i_req0_wdata;
    logic               o_req0_ready;
    logic [NB_DATA-1:0] o_req0_rdata;

    logic               i_req1_valid;
    logic               i_req1_we;
    logic [1:0]         i_req1_size;
    logic [NB_ADDR-1:0] i_req1_addr;
    logic [NB_DATA-1:0] i_req1_wdata;
    logic               o_req1_ready;
    logic [NB_DATA-1:0] o_req1_rdata;

    logic               o_ram_we;
    logic [NB_ADDR-1:0] o_ram_addr;
    logic [NB_DATA-1:0] o_ram_wdata;
    logic [NB_DATA-1:0] i_ram_rdata;

    logic               o_busy;
    logic               o_addr_err;
    logic               i_err_clr;

    modport master (
        output i_req0_valid, i_req0_we, i_req0_size, i_req0_addr, i_req0_wdata,
        input  o_req0_ready, o_req0_rdata,
        output i_req1_valid, i_req1_we, i_req1_size, i_req1_addr, i_req1_wdata,
        input  o_req1_ready, o_req1_rdata,
        input  o_ram_we, o_ram_addr, o_ram_wdata,
        output i_ram_rdata,
        input  o_busy, o_addr_err,
        output i_err_clr
    );

    modport slave (
        input  i_req0_valid, i_req0_we, i_req0_size, i_req0_addr, i_req0_wdata,
        output o_req0_ready, o_req0_rdata,
        input  i_req1_valid, i_req1_we, i_req1_size, i_req1_addr, i_req1_wdata,
        output o_req1_ready, o_req1_rdata,
        output o_ram_we, o_ram_addr, o_ram_wdata,
        input  i_ram_rdata,
        output o_busy, o_addr_err,
        input  i_err_clr
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - two-port arbiter/sequencer for a 32-bit single-port async-read RAM
// Optional feature macro: DEBUG_PRIORITY_EN (port 1 wins ties; otherwise round-robin).
// Ports:
//   clk      - rising-edge clock
//   i_reset  - asynchronous active-high reset
//   bus      - ram_access_ctrl_if.slave:
//              req0 (CPU) / req1 (debug): valid, we, size, addr, wdata in; ready pulse, rdata out
//              RAM: o_ram_we, o_ram_addr, o_ram_wdata out; i_ram_rdata in (addr byte = [31:24])
//              status: o_busy (not IDLE), o_addr_err (sticky), i_err_clr in
module ram_access_ctrl #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic             clk,
    input  logic             i_reset,
    ram_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RMW_WR = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    // Highest start address whose 4-byte window still fits in the array.
    localparam logic [NB_ADDR-1:0] ADDR_LIMIT = {{(NB_ADDR-2){1'b1}}, 2'b00};

    state_t             state;
    state_t             state_nxt;

    logic               cap_port;
    logic               cap_we;
    logic               cap_err;
    logic [1:0]         cap_size;
    logic [NB_ADDR-1:0] cap_addr;
    // Holds the store data after grant, then the merged word for RMW; drives o_ram_wdata.
    logic [NB_DATA-1:0] wdata_q;
    logic [NB_DATA-1:0] rdata0_q;
    logic [NB_DATA-1:0] rdata1_q;
    logic               ready0_q;
    logic               ready1_q;
    logic               addr_err_q;
`ifndef DEBUG_PRIORITY_EN
    logic               rr_last;
`endif

    logic               req_any;
    logic               grant;
    logic               grant_port;
    logic               sel_we;
    logic [1:0]         sel_size;
    logic [NB_ADDR-1:0] sel_addr;
    logic [NB_DATA-1:0] sel_wdata;
    logic               subword;
    logic               ram_we;
    logic               done;
    logic [NB_DATA-1:0] load_fmt;
    logic [NB_DATA-1:0] merged;

    always_comb begin
        req_any = bus.i_req0_valid | bus.i_req1_valid;
`ifdef DEBUG_PRIORITY_EN
        grant_port = bus.i_req1_valid;
`else
        grant_port = (bus.i_req0_valid & bus.i_req1_valid) ? ~rr_last : bus.i_req1_valid;
`endif
        // The requester just completed still holds valid during its ready cycle,
        // so no grant is allowed until the following cycle.
        grant     = (state == IDLE) & req_any & ~ready0_q & ~ready1_q;
        sel_we    = grant_port ? bus.i_req1_we    : bus.i_req0_we;
        sel_size  = grant_port ? bus.i_req1_size  : bus.i_req0_size;
        sel_addr  = grant_port ? bus.i_req1_addr  : bus.i_req0_addr;
        sel_wdata = grant_port ? bus.i_req1_wdata : bus.i_req0_wdata;
    end

    always_comb begin
        subword = cap_we & ~cap_err & ((cap_size == SZ_BYTE) | (cap_size == SZ_HALF));
        case (cap_size)
            SZ_BYTE: load_fmt = {{(NB_DATA-8){1'b0}}, bus.i_ram_rdata[NB_DATA-1 -: 8]};
            SZ_HALF: load_fmt = {{(NB_DATA-16){1'b0}}, bus.i_ram_rdata[NB_DATA-1 -: 16]};
            default: load_fmt = bus.i_ram_rdata;
        endcase
        // New bytes occupy the top of the window (lowest addresses), old bytes fill the rest.
        if (cap_size == SZ_BYTE) begin
            merged = {wdata_q[7:0], bus.i_ram_rdata[NB_DATA-9:0]};
        end else begin
            merged = {wdata_q[15:0], bus.i_ram_rdata[NB_DATA-17:0]};
        end
    end

    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (subword) begin
                    state_nxt = RMW_WR;
                end else begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                    ram_we    = cap_we & ~cap_err;
                end
            end
            RMW_WR: begin
                ram_we    = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            cap_port   <= 1'b0;
            cap_we     <= 1'b0;
            cap_err    <= 1'b0;
            cap_size   <= 2'b00;
            cap_addr   <= '0;
            wdata_q    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            ready0_q   <= 1'b0;
            ready1_q   <= 1'b0;
            addr_err_q <= 1'b0;
`ifndef DEBUG_PRIORITY_EN
            rr_last    <= 1'b1;
`endif
        end else begin
            state    <= state_nxt;
            ready0_q <= done & ~cap_port;
            ready1_q <= done & cap_port;
            if (grant) begin
                cap_port <= grant_port;
                cap_we   <= sel_we;
                cap_size <= sel_size;
                cap_addr <= sel_addr;
                cap_err  <= (sel_addr > ADDR_LIMIT);
                wdata_q  <= sel_wdata;
`ifndef DEBUG_PRIORITY_EN
                rr_last  <= grant_port;
`endif
            end
            if ((state == ACCESS) && subword) begin
                wdata_q <= merged;
            end
            if ((state == ACCESS) && !cap_we) begin
                if (cap_port) begin
                    rdata1_q <= cap_err ? '0 : load_fmt;
                end else begin
                    rdata0_q <= cap_err ? '0 : load_fmt;
                end
            end
            if ((state == ACCESS) && cap_err) begin
                addr_err_q <= 1'b1;
            end else if (bus.i_err_clr) begin
                addr_err_q <= 1'b0;
            end
        end
    end

    assign bus.o_req0_ready = ready0_q;
    assign bus.o_req1_ready = ready1_q;
    assign bus.o_req0_rdata = rdata0_q;
    assign bus.o_req1_rdata = rdata1_q;
    assign bus.o_ram_we     = ram_we;
    assign bus.o_ram_addr   = cap_addr;
    assign bus.o_ram_wdata  = wdata_q;
    assign bus.o_busy       = (state != IDLE);
    assign bus.o_addr_err   = addr_err_q;
endmodule
